// File: rtl/vga_pkg.sv
// Shared sizing defaults, clear-engine state encoding and a constant clog2 helper
// for the VGA text buffer slice.
package vga_pkg;

   localparam int unsigned H_TILES        = 80;
   localparam int unsigned V_TILES        = 30;
   localparam int unsigned CHAR_WIDTH     = 7;
   localparam int unsigned CHARS_PER_WORD = 4;
   localparam int unsigned AXI_DATA_WIDTH = 8 * CHARS_PER_WORD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } clr_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) >= 64'(value)) return i;
      end
      return 32;
   endfunction

endpackage

// File: rtl/vga_text_buffer_if.sv
// Bundle of the AXI write/read, VGA read, scroll and clear-engine signals of the
// text buffer; the slave modport is the buffer side.
interface vga_text_buffer_if #(
   parameter int unsigned H_TILES        = vga_pkg::H_TILES,
   parameter int unsigned V_TILES        = vga_pkg::V_TILES,
   parameter int unsigned CHAR_WIDTH     = vga_pkg::CHAR_WIDTH,
   parameter int unsigned CHARS_PER_WORD = vga_pkg::CHARS_PER_WORD,
   parameter int unsigned AXI_DATA_WIDTH = vga_pkg::AXI_DATA_WIDTH
);
   localparam int unsigned WORDS_PER_ROW = H_TILES / CHARS_PER_WORD;
   localparam int unsigned NUM_ADDRS     = WORDS_PER_ROW * V_TILES;
   localparam int unsigned ADDR_WIDTH    = vga_pkg::clog2(NUM_ADDRS);
   localparam int unsigned ROW_WIDTH     = vga_pkg::clog2(V_TILES);
   localparam int unsigned COL_WIDTH     = vga_pkg::clog2(WORDS_PER_ROW);

   logic                                 wr_en;
   logic [ADDR_WIDTH-1:0]                w_addr;
   logic [CHARS_PER_WORD-1:0]            w_strb;
   logic [AXI_DATA_WIDTH-1:0]            din;
   logic                                 r_req;
   logic [ADDR_WIDTH-1:0]                r_addr;
   logic [AXI_DATA_WIDTH-1:0]            r_data;
   logic                                 r_valid;
   logic [ROW_WIDTH-1:0]                 vr_row;
   logic [COL_WIDTH-1:0]                 vr_col;
   logic [CHARS_PER_WORD*CHAR_WIDTH-1:0] dout;
   logic                                 frame_start;
   logic                                 scroll_we;
   logic [ROW_WIDTH-1:0]                 scroll;
   logic [ROW_WIDTH-1:0]                 scroll_row;
   logic                                 clr_start;
   logic [CHAR_WIDTH-1:0]                fill_char;
   logic                                 busy;
   logic                                 wr_drop;

   modport master (
      output wr_en, w_addr, w_strb, din, r_req, r_addr, vr_row, vr_col,
             frame_start, scroll_we, scroll, clr_start, fill_char,
      input  r_data, r_valid, dout, scroll_row, busy, wr_drop
   );

   modport slave (
      input  wr_en, w_addr, w_strb, din, r_req, r_addr, vr_row, vr_col,
             frame_start, scroll_we, scroll, clr_start, fill_char,
      output r_data, r_valid, dout, scroll_row, busy, wr_drop
   );

endinterface

// File: rtl/vga_clear_fsm.sv
// Clear-screen fill engine: sweeps every word address once with the latched
// fill character replicated across all lanes.
module vga_clear_fsm #(
   parameter int unsigned NUM_ADDRS      = 600,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned CHAR_WIDTH     = 7,
   parameter int unsigned CHARS_PER_WORD = 4
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr_start,
   input  logic [CHAR_WIDTH-1:0]                fill_char,
   output logic                                 fill_we,
   output logic [ADDR_WIDTH-1:0]                fill_addr,
   output logic [CHARS_PER_WORD*CHAR_WIDTH-1:0] fill_data,
   output logic                                 busy
);
   import vga_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDRS - 1);

   clr_state_t            state, state_next;
   logic [ADDR_WIDTH-1:0] count;
   logic [CHAR_WIDTH-1:0] fill_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         fill_q <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && clr_start) begin
            count  <= '0;
            fill_q <= fill_char;
         end else if (state == FILL) begin
            count <= count + ADDR_WIDTH'(1);
         end
      end
   end

   // DONE adds one trailing busy cycle after the last word is written
   always_comb begin
      state_next = state;
      fill_we    = 1'b0;
      busy       = 1'b0;
      unique case (state)
         IDLE: if (clr_start) state_next = FILL;
         FILL: begin
            fill_we = 1'b1;
            busy    = 1'b1;
            if (count == LAST_ADDR) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign fill_addr = count;
   assign fill_data = {CHARS_PER_WORD{fill_q}};

endmodule

// File: rtl/vga_text_buffer.sv
// Packed character store with strobed AXI write, registered AXI read, two-stage
// scrolled VGA read port and a whole-screen clear engine.
module vga_text_buffer #(
   parameter int unsigned H_TILES        = vga_pkg::H_TILES,
   parameter int unsigned V_TILES        = vga_pkg::V_TILES,
   parameter int unsigned CHAR_WIDTH     = vga_pkg::CHAR_WIDTH,
   parameter int unsigned CHARS_PER_WORD = vga_pkg::CHARS_PER_WORD,
   parameter int unsigned AXI_DATA_WIDTH = vga_pkg::AXI_DATA_WIDTH
)(
   input logic              clk,
   input logic              rst,
   vga_text_buffer_if.slave bus
);
   localparam int unsigned WORDS_PER_ROW = H_TILES / CHARS_PER_WORD;
   localparam int unsigned NUM_ADDRS     = WORDS_PER_ROW * V_TILES;
   localparam int unsigned ADDR_WIDTH    = vga_pkg::clog2(NUM_ADDRS);
   localparam int unsigned ROW_WIDTH     = vga_pkg::clog2(V_TILES);
   localparam int unsigned COL_WIDTH     = vga_pkg::clog2(WORDS_PER_ROW);
   localparam int unsigned WORD_WIDTH    = CHARS_PER_WORD * CHAR_WIDTH;

   localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(NUM_ADDRS);
   localparam logic [ROW_WIDTH:0]    ROW_LIMIT  = (ROW_WIDTH+1)'(V_TILES);
   localparam logic [COL_WIDTH:0]    COL_LIMIT  = (COL_WIDTH+1)'(WORDS_PER_ROW);
   localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(WORDS_PER_ROW);

   logic [WORD_WIDTH-1:0]     mem [NUM_ADDRS];
   logic                      fill_we, busy, axi_we;
   logic [ADDR_WIDTH-1:0]     fill_addr;
   logic [WORD_WIDTH-1:0]     fill_data;
   logic [AXI_DATA_WIDTH-1:0] rd_word;
   logic [ROW_WIDTH-1:0]      scroll_pend, prow;
   logic [ROW_WIDTH:0]        row_sum;
   logic [ADDR_WIDTH-1:0]     paddr_next, paddr;
   logic                      col_ok_next, col_ok;
   logic                      unused_pad_bits;

   vga_clear_fsm #(
      .NUM_ADDRS      (NUM_ADDRS),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CHAR_WIDTH     (CHAR_WIDTH),
      .CHARS_PER_WORD (CHARS_PER_WORD)
   ) u_clear (
      .clk       (clk),
      .rst       (rst),
      .clr_start (bus.clr_start),
      .fill_char (bus.fill_char),
      .fill_we   (fill_we),
      .fill_addr (fill_addr),
      .fill_data (fill_data),
      .busy      (busy)
   );

   assign bus.busy        = busy;
   assign axi_we          = bus.wr_en && !busy && ({1'b0, bus.w_addr} < ADDR_LIMIT);
   assign unused_pad_bits = ^bus.din;

   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[fill_addr] <= fill_data;
      end else if (axi_we) begin
         for (int unsigned k = 0; k < CHARS_PER_WORD; k++) begin
            if (bus.w_strb[k])
               mem[bus.w_addr][k*CHAR_WIDTH +: CHAR_WIDTH] <= bus.din[8*k +: CHAR_WIDTH];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if ({1'b0, bus.r_addr} < ADDR_LIMIT) begin
         for (int unsigned k = 0; k < CHARS_PER_WORD; k++)
            rd_word[8*k +: CHAR_WIDTH] = mem[bus.r_addr][k*CHAR_WIDTH +: CHAR_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.r_data  <= '0;
         bus.r_valid <= 1'b0;
         bus.wr_drop <= 1'b0;
      end else begin
         bus.r_valid <= bus.r_req;
         bus.wr_drop <= bus.wr_en && busy;
         if (bus.r_req) bus.r_data <= rd_word;
      end
   end

   // Pending value moves to the active offset only at frame start; loading and
   // copying in the same cycle therefore copies the previous pending value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scroll_pend    <= '0;
         bus.scroll_row <= '0;
      end else begin
         if (bus.scroll_we && ({1'b0, bus.scroll} < ROW_LIMIT)) scroll_pend <= bus.scroll;
         if (bus.frame_start) bus.scroll_row <= scroll_pend;
      end
   end

   always_comb begin
      row_sum     = {1'b0, bus.vr_row} + {1'b0, bus.scroll_row};
      prow        = (row_sum >= ROW_LIMIT) ? ROW_WIDTH'(row_sum - ROW_LIMIT)
                                           : row_sum[ROW_WIDTH-1:0];
      paddr_next  = ADDR_WIDTH'(prow) * ROW_STRIDE + ADDR_WIDTH'(bus.vr_col);
      col_ok_next = {1'b0, bus.vr_col} < COL_LIMIT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         paddr    <= '0;
         col_ok   <= 1'b0;
         bus.dout <= '0;
      end else begin
         paddr  <= paddr_next;
         col_ok <= col_ok_next;
         if (col_ok && ({1'b0, paddr} < ADDR_LIMIT)) bus.dout <= mem[paddr];
         else                                         bus.dout <= '0;
      end
   end

endmodule
